// File: rtl/reduce_result_injector_pkg.sv
// Shared definitions for the reduction-result injector.
// Flit layout (FLIT_W = PayloadWidth + HDR_W):
//   [PayloadWidth-1:0]             payload
//   [PayloadWidth+DST_X_OFF +: 3]  destination X
//   [PayloadWidth+DST_Y_OFF +: 3]  destination Y
//   [PayloadWidth+DST_Z_OFF +: 3]  destination Z
//   [PayloadWidth+VALID_OFF]       flit valid bit (MSB)
// Remaining header bits are carried through untouched.
package reduce_result_injector_pkg;

   localparam int HDR_W     = 50;
   localparam int DST_X_OFF = 0;
   localparam int DST_Y_OFF = 3;
   localparam int DST_Z_OFF = 6;
   localparam int VALID_OFF = 49;
   localparam int NUM_INJ   = 6;

   // Port indices; inject_bus slot i carries port i.
   typedef enum logic [2:0] {
      PORT_XPOS  = 3'd0,
      PORT_YPOS  = 3'd1,
      PORT_ZPOS  = 3'd2,
      PORT_XNEG  = 3'd3,
      PORT_YNEG  = 3'd4,
      PORT_ZNEG  = 3'd5,
      PORT_LOCAL = 3'd6
   } port_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Forward ring distance (dst - cur) mod dim; coordinates are assumed < dim.
   function automatic logic [2:0] ring_dist(input logic [2:0] dst, input logic [2:0] cur,
                                            input int dim);
      logic [4:0] sum;
      sum = {2'b00, dst} + 5'(dim) - {2'b00, cur};
      if (sum >= 5'(dim)) begin
         sum = sum - 5'(dim);
      end else begin
         sum = sum;
      end
      return 3'(sum);
   endfunction

endpackage

// File: rtl/reduce_result_injector_if.sv
// Handshake bundle between the reduce unit / router / kernel and the injector.
//   in_flit, in_children, in_valid, in_ready : push side from the reduce unit
//   inject_bus, inject_ready                 : six router inject ports
//   local_flit, local_valid, local_ready     : local kernel port
//   overflow_cnt                             : dropped-flit counter
// slave = the injector, master = its environment.
interface reduce_result_injector_if
   import reduce_result_injector_pkg::*;
#(
   parameter int FLIT_W  = 32 + HDR_W,
   parameter int CHILD_W = 3
);
   localparam int FC_W = FLIT_W + CHILD_W;

   logic [FLIT_W-1:0]         in_flit;
   logic [CHILD_W-1:0]        in_children;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_INJ*FC_W-1:0]   inject_bus;
   logic [NUM_INJ-1:0]        inject_ready;
   logic [FLIT_W-1:0]         local_flit;
   logic                      local_valid;
   logic                      local_ready;
   logic [7:0]                overflow_cnt;

   modport master (
      output in_flit, in_children, in_valid, inject_ready, local_ready,
      input  in_ready, inject_bus, local_flit, local_valid, overflow_cnt
   );

   modport slave (
      input  in_flit, in_children, in_valid, inject_ready, local_ready,
      output in_ready, inject_bus, local_flit, local_valid, overflow_cnt
   );
endinterface

// File: rtl/reduce_result_injector_route_calc.sv
// Combinational dimension-order router for the head flit.
//   dst_x/dst_y/dst_z : destination coordinates of the flit
//   port              : selected port (X, then Y, then Z; local when all distances are 0)
// A ring distance of exactly DIM/2 resolves to the positive direction.
module inject_route_calc
   import reduce_result_injector_pkg::*;
#(
   parameter logic [2:0] cur_x = 3'd0,
   parameter logic [2:0] cur_y = 3'd0,
   parameter logic [2:0] cur_z = 3'd0,
   parameter int         DIM   = 4
) (
   input  logic [2:0] dst_x,
   input  logic [2:0] dst_y,
   input  logic [2:0] dst_z,
   output port_e      port
);
   localparam logic [2:0] HALF = 3'(DIM / 2);

   logic [2:0] dx_s;
   logic [2:0] dy_s;
   logic [2:0] dz_s;
   port_e      port_s;

   // Per-dimension forward distances.
   always_comb begin
      dx_s = ring_dist(dst_x, cur_x, DIM);
      dy_s = ring_dist(dst_y, cur_y, DIM);
      dz_s = ring_dist(dst_z, cur_z, DIM);
   end

   // First non-zero dimension decides; direction by shortest way round the ring.
   always_comb begin
      port_s = PORT_LOCAL;
      if (dx_s != 3'd0) begin
         if (dx_s <= HALF) port_s = PORT_XPOS; else port_s = PORT_XNEG;
      end else if (dy_s != 3'd0) begin
         if (dy_s <= HALF) port_s = PORT_YPOS; else port_s = PORT_YNEG;
      end else if (dz_s != 3'd0) begin
         if (dz_s <= HALF) port_s = PORT_ZPOS; else port_s = PORT_ZNEG;
      end else begin
         port_s = PORT_LOCAL;
      end
   end

   assign port = port_s;
endmodule

// File: rtl/reduce_result_injector.sv
// Buffers completed reduction flits and hands each one to its router inject port or to
// the local kernel over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of reduce_result_injector_if (push, inject, local, overflow)
// A DEPTH-entry FIFO feeds a two-state output stage; the output stage pops and reloads
// on the same edge as a hand-off, giving one flit per cycle while ready stays high.
module reduce_result_injector
   import reduce_result_injector_pkg::*;
#(
   parameter logic [2:0] cur_x        = 3'd0,
   parameter logic [2:0] cur_y        = 3'd0,
   parameter logic [2:0] cur_z        = 3'd0,
   parameter int         DIM          = 4,
   parameter int         lg_numprocs  = 3,
   parameter int         PayloadWidth = 32,
   parameter int         DEPTH        = 4
) (
   input logic                     clk,
   input logic                     rst,
   reduce_result_injector_if.slave bus
);
   localparam int FLIT_W    = PayloadWidth + HDR_W;
   localparam int FC_W      = FLIT_W + lg_numprocs;
   localparam int AW        = $clog2(DEPTH);
   localparam int VALID_POS = PayloadWidth + VALID_OFF;

   logic [FC_W-1:0]         mem_r [DEPTH];
   logic [AW:0]             wr_ptr_r;
   logic [AW:0]             rd_ptr_r;
   logic [7:0]              overflow_r;
   state_e                  state_r;
   port_e                   sel_r;
   logic [NUM_INJ*FC_W-1:0] inject_bus_r;
   logic [FLIT_W-1:0]       local_flit_r;
   logic                    local_valid_r;

   logic                    empty_s;
   logic                    full_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    drop_s;
   logic                    sel_ready_s;
   logic                    handoff_s;
   logic [FC_W-1:0]         head_s;
   port_e                   head_port_s;
   logic [NUM_INJ*FC_W-1:0] load_bus_s;
   logic [FLIT_W-1:0]       load_local_s;

   // The extra pointer bit tells full from empty when the index bits match.
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

   // Push qualification: flits with the valid bit clear are ignored outright.
   always_comb begin
      push_s = 1'b0;
      drop_s = 1'b0;
      if (bus.in_valid && bus.in_flit[VALID_POS]) begin
         push_s = !full_s;
         drop_s = full_s;
      end else begin
         push_s = 1'b0;
         drop_s = 1'b0;
      end
   end

   // Ready of the port currently owned by the output register.
   always_comb begin
      sel_ready_s = 1'b0;
      case (sel_r)
         PORT_XPOS:  sel_ready_s = bus.inject_ready[0];
         PORT_YPOS:  sel_ready_s = bus.inject_ready[1];
         PORT_ZPOS:  sel_ready_s = bus.inject_ready[2];
         PORT_XNEG:  sel_ready_s = bus.inject_ready[3];
         PORT_YNEG:  sel_ready_s = bus.inject_ready[4];
         PORT_ZNEG:  sel_ready_s = bus.inject_ready[5];
         PORT_LOCAL: sel_ready_s = bus.local_ready;
         default:    sel_ready_s = 1'b0;
      endcase
   end

   assign handoff_s = (state_r == ST_HOLD) && sel_ready_s;
   assign pop_s     = !empty_s && ((state_r == ST_IDLE) || handoff_s);

   inject_route_calc #(
      .cur_x (cur_x),
      .cur_y (cur_y),
      .cur_z (cur_z),
      .DIM   (DIM)
   ) u_route (
      .dst_x (head_s[PayloadWidth+DST_X_OFF +: 3]),
      .dst_y (head_s[PayloadWidth+DST_Y_OFF +: 3]),
      .dst_z (head_s[PayloadWidth+DST_Z_OFF +: 3]),
      .port  (head_port_s)
   );

   // Output image of the head flit: only its own slot is non-zero.
   always_comb begin
      load_bus_s   = '0;
      load_local_s = '0;
      for (int i = 0; i < NUM_INJ; i++) begin
         if (head_port_s == port_e'(i)) begin
            load_bus_s[i*FC_W +: FC_W] = head_s;
         end else begin
            load_bus_s[i*FC_W +: FC_W] = '0;
         end
      end
      if (head_port_s == PORT_LOCAL) begin
         load_local_s = head_s[FLIT_W-1:0];
      end else begin
         load_local_s = '0;
      end
   end

   // FIFO storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_children, bus.in_flit};
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // Saturating count of valid flits dropped on a full FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_r <= 8'd0;
      end else if (drop_s && (overflow_r != 8'hFF)) begin
         overflow_r <= overflow_r + 8'd1;
      end
   end

   // Output FSM: owns the single output register and drives the ports from it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         sel_r         <= PORT_LOCAL;
         inject_bus_r  <= '0;
         local_flit_r  <= '0;
         local_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  state_r       <= ST_HOLD;
                  sel_r         <= head_port_s;
                  inject_bus_r  <= load_bus_s;
                  local_flit_r  <= load_local_s;
                  local_valid_r <= (head_port_s == PORT_LOCAL);
               end
            end
            ST_HOLD: begin
               // Without a hand-off everything holds bit-stable.
               if (handoff_s) begin
                  if (pop_s) begin
                     sel_r         <= head_port_s;
                     inject_bus_r  <= load_bus_s;
                     local_flit_r  <= load_local_s;
                     local_valid_r <= (head_port_s == PORT_LOCAL);
                  end else begin
                     state_r       <= ST_IDLE;
                     sel_r         <= PORT_LOCAL;
                     inject_bus_r  <= '0;
                     local_flit_r  <= '0;
                     local_valid_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               sel_r         <= PORT_LOCAL;
               inject_bus_r  <= '0;
               local_flit_r  <= '0;
               local_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = !full_s;
   assign bus.inject_bus   = inject_bus_r;
   assign bus.local_flit   = local_flit_r;
   assign bus.local_valid  = local_valid_r;
   assign bus.overflow_cnt = overflow_r;
endmodule

// File: tb/tb_reduce_result_injector.sv
// Scoreboard bench for reduce_result_injector at node (1,1,1), DIM=4.
// Stimulus pushes flits and queues the expected {port, children+flit}; a negedge monitor
// pops the queue on every hand-off and compares the whole output image.
module tb_reduce_result_injector;
   import reduce_result_injector_pkg::*;

   localparam int PW        = 32;
   localparam int CW        = 3;
   localparam int FLIT_W    = PW + HDR_W;
   localparam int FC_W      = FLIT_W + CW;
   localparam int VALID_POS = PW + VALID_OFF;

   typedef struct {
      int              port;
      logic [FC_W-1:0] data;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   hand_cyc_q[$];
   int   cyc;
   int   n_cmp;
   int   n_err;

   reduce_result_injector_if #(.FLIT_W(FLIT_W), .CHILD_W(CW)) bus_if ();

   reduce_result_injector #(
      .cur_x(3'd1), .cur_y(3'd1), .cur_z(3'd1), .DIM(4),
      .lg_numprocs(CW), .PayloadWidth(PW), .DEPTH(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FLIT_W-1:0] mk_flit(input logic [2:0] dx, input logic [2:0] dy,
                                                 input logic [2:0] dz, input logic [31:0] pl);
      logic [FLIT_W-1:0] f;
      f = '0;
      f[PW-1:0]            = pl;
      f[PW+DST_X_OFF +: 3] = dx;
      f[PW+DST_Y_OFF +: 3] = dy;
      f[PW+DST_Z_OFF +: 3] = dz;
      f[VALID_POS]         = 1'b1;
      return f;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One push cycle; port < 0 means the flit is expected to be dropped/ignored.
   task automatic push(input logic [FLIT_W-1:0] f, input logic [CW-1:0] ch, input int port);
      exp_t e;
      bus_if.in_flit     = f;
      bus_if.in_children = ch;
      bus_if.in_valid    = 1'b1;
      if (port >= 0) begin
         e.port = port;
         e.data = {ch, f};
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check(name, 512'(exp_q.size()), 512'(0));
   endtask

   // Monitor: a hand-off happens at the next posedge wherever valid meets ready.
   always @(negedge clk) begin
      logic                      hand;
      exp_t                      e;
      logic [6*FC_W-1:0]         eb;
      logic [FLIT_W-1:0]         el;
      if (rst) begin
         hand = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (bus_if.inject_bus[i*FC_W + VALID_POS] && bus_if.inject_ready[i]) hand = 1'b1;
         end
         if (bus_if.local_valid && bus_if.local_ready) hand = 1'b1;
         if (hand) begin
            hand_cyc_q.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL handoff: unexpected flit, bus %0h local %0h, none queued",
                        bus_if.inject_bus, bus_if.local_flit);
            end else begin
               e  = exp_q.pop_front();
               eb = '0;
               el = '0;
               if (e.port < 6) eb[e.port*FC_W +: FC_W] = e.data;
               else            el = e.data[FLIT_W-1:0];
               if (bus_if.inject_bus !== eb || bus_if.local_flit !== el ||
                   bus_if.local_valid !== (e.port == 6)) begin
                  n_err++;
                  $display("FAIL handoff: got bus %0h local %0h/%0b expected port %0d data %0h",
                           bus_if.inject_bus, bus_if.local_flit, bus_if.local_valid,
                           e.port, e.data);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [FLIT_W-1:0] fa;
      logic [FLIT_W-1:0] fb;
      logic [FLIT_W-1:0] bad;
      cyc   = 0;
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      bus_if.in_flit      = '0;
      bus_if.in_children  = '0;
      bus_if.in_valid     = 1'b0;
      bus_if.inject_ready = 6'b111111;
      bus_if.local_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus",      512'(bus_if.inject_bus),   512'(0));
      check("rst_lflit",    512'(bus_if.local_flit),   512'(0));
      check("rst_lvalid",   512'(bus_if.local_valid),  512'(0));
      check("rst_in_ready", 512'(bus_if.in_ready),     512'(1));
      check("rst_overflow", 512'(bus_if.overflow_cnt), 512'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // Test 1: X tie -> pos, X neg, Y pos; plus an invalid-bit flit that must vanish.
      push(mk_flit(3'd3, 3'd1, 3'd1, 32'h0000_1111), 3'd1, 0);
      push(mk_flit(3'd0, 3'd1, 3'd1, 32'h0000_2222), 3'd2, 3);
      push(mk_flit(3'd1, 3'd2, 3'd0, 32'h0000_3333), 3'd3, 1);
      bad = mk_flit(3'd3, 3'd1, 3'd1, 32'h0BAD_0BAD);
      bad[VALID_POS] = 1'b0;
      push(bad, 3'd7, -1);
      wait_drain("t1_drain");
      check("t1_overflow", 512'(bus_if.overflow_cnt), 512'(0));

      // Test 2: local delivery with the payload intact and inject_bus silent.
      bus_if.local_ready = 1'b0;
      push(mk_flit(3'd1, 3'd1, 3'd1, 32'hDEAD_BEEF), 3'd5, 6);
      @(posedge clk); #1;
      check("t2_lvalid",  512'(bus_if.local_valid),      512'(1));
      check("t2_payload", 512'(bus_if.local_flit[31:0]), 512'(32'hDEAD_BEEF));
      check("t2_bus",     512'(bus_if.inject_bus),       512'(0));
      bus_if.local_ready = 1'b1;
      wait_drain("t2_drain");

      // Test 3: xpos held 5 cycles under backpressure, then one hand-off and the next flit.
      bus_if.inject_ready = 6'b111110;
      fa = mk_flit(3'd2, 3'd1, 3'd1, 32'hAAAA_0001);
      fb = mk_flit(3'd1, 3'd2, 3'd1, 32'hBBBB_0002);
      push(fa, 3'd4, 0);
      push(fb, 3'd6, 1);
      for (int k = 0; k < 5; k++) begin
         check("t3_hold", 512'(bus_if.inject_bus), 512'({3'd4, fa}));
         @(posedge clk); #1;
      end
      bus_if.inject_ready = 6'b111111;
      @(posedge clk); #1;
      check("t3_next", 512'(bus_if.inject_bus), 512'({3'd6, fb}) << FC_W);
      wait_drain("t3_drain");

      // Test 4: all ports blocked. A blocker fills the output register first, so of the
      // next six pushes four fit in the FIFO and two are dropped.
      bus_if.inject_ready = 6'b000000;
      bus_if.local_ready  = 1'b0;
      push(mk_flit(3'd2, 3'd1, 3'd1, 32'hC0C0_0000), 3'd0, 0);
      push(mk_flit(3'd1, 3'd0, 3'd1, 32'hC0C0_0001), 3'd1, 4);
      push(mk_flit(3'd1, 3'd1, 3'd3, 32'hC0C0_0002), 3'd2, 2);
      push(mk_flit(3'd1, 3'd1, 3'd0, 32'hC0C0_0003), 3'd3, 5);
      check("t4_ready_3", 512'(bus_if.in_ready), 512'(1));
      push(mk_flit(3'd1, 3'd1, 3'd1, 32'hC0C0_0004), 3'd4, 6);
      check("t4_ready_4", 512'(bus_if.in_ready), 512'(0));
      push(mk_flit(3'd0, 3'd1, 3'd1, 32'hC0C0_0005), 3'd5, -1);
      push(mk_flit(3'd1, 3'd2, 3'd0, 32'hC0C0_0006), 3'd6, -1);
      push(bad, 3'd7, -1);
      check("t4_overflow", 512'(bus_if.overflow_cnt), 512'(2));
      bus_if.inject_ready = 6'b111111;
      bus_if.local_ready  = 1'b1;
      wait_drain("t4_drain");
      check("t4_ready_after", 512'(bus_if.in_ready), 512'(1));

      // Test 5: reset while holding a flit with two more queued behind it.
      bus_if.inject_ready = 6'b000000;
      bus_if.local_ready  = 1'b0;
      push(mk_flit(3'd2, 3'd1, 3'd1, 32'hD0D0_0001), 3'd1, -1);
      push(mk_flit(3'd1, 3'd2, 3'd1, 32'hD0D0_0002), 3'd2, -1);
      push(mk_flit(3'd1, 3'd1, 3'd2, 32'hD0D0_0003), 3'd3, -1);
      check("t5_held", 512'(bus_if.inject_bus[VALID_POS]), 512'(1));
      #2;
      rst = 1'b0;
      #1;
      check("t5_bus",      512'(bus_if.inject_bus),   512'(0));
      check("t5_lvalid",   512'(bus_if.local_valid),  512'(0));
      check("t5_in_ready", 512'(bus_if.in_ready),     512'(1));
      check("t5_overflow", 512'(bus_if.overflow_cnt), 512'(0));
      @(negedge clk);
      rst = 1'b1;
      bus_if.inject_ready = 6'b111111;
      bus_if.local_ready  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t5_empty_bus", 512'(bus_if.inject_bus),  512'(0));
      check("t5_empty_lv",  512'(bus_if.local_valid), 512'(0));

      // Test 6: eight back-to-back pushes must leave on eight consecutive cycles.
      base = hand_cyc_q.size();
      push(mk_flit(3'd2, 3'd1, 3'd1, 32'hE000_0000), 3'd0, 0);
      push(mk_flit(3'd1, 3'd0, 3'd1, 32'hE000_0001), 3'd1, 4);
      push(mk_flit(3'd1, 3'd1, 3'd3, 32'hE000_0002), 3'd2, 2);
      push(mk_flit(3'd1, 3'd1, 3'd0, 32'hE000_0003), 3'd3, 5);
      push(mk_flit(3'd1, 3'd1, 3'd1, 32'hE000_0004), 3'd4, 6);
      push(mk_flit(3'd0, 3'd1, 3'd1, 32'hE000_0005), 3'd5, 3);
      push(mk_flit(3'd1, 3'd2, 3'd0, 32'hE000_0006), 3'd6, 1);
      push(mk_flit(3'd1, 3'd1, 3'd2, 32'hE000_0007), 3'd7, 2);
      wait_drain("t6_drain");
      check("t6_count", 512'(hand_cyc_q.size() - base), 512'(8));
      if (hand_cyc_q.size() >= base + 8) begin
         check("t6_span", 512'(hand_cyc_q[base+7] - hand_cyc_q[base]), 512'(7));
      end else begin
         check("t6_span", 512'(hand_cyc_q.size() - base), 512'(8));
      end
      check("t6_overflow", 512'(bus_if.overflow_cnt), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
